stage_sequencer: RTL

//  Multicycle control sequencer for the RV64 datapath. Drives the one-hot stage

---
 rtl/stage_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/stage_sequencer.sv
// stage_sequencer: multicycle stage sequencer for the RV64 datapath.
// Ports: clk, reset (sync, high), run, opcode, mem_ready -> one-hot stage
//   strobes stateIF..stateWB, halted, mem_err, cycle_count, instr_count.
module stage_sequencer #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             stateIF,
  output logic             stateID,
  output logic             stateEXE,
  output logic             stateMEM,
  output logic             stateWB,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_IF, S_ID, S_EXE, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_LOAD, C_STORE, C_BRANCH, C_SYSTEM, C_NOP
  } cls_t;

  state_t        state;
  state_t        nxt;
  cls_t          cls;
  cls_t          cls_id;
  logic [WW-1:0] wait_cnt;
  logic          retire;
  logic          to_err;
  logic          active;

  always_comb begin
    cls_id = C_NOP;
    unique case (1'b1)
      opcode == 7'b0110011,
      opcode == 7'b0010011: cls_id = C_ALU;
      opcode == 7'b0000011: cls_id = C_LOAD;
      opcode == 7'b0100011: cls_id = C_STORE;
      opcode == 7'b1100011: cls_id = C_BRANCH;
      opcode == 7'b1110011: cls_id = C_SYSTEM;
      default:              cls_id = C_NOP;
    endcase
  end

  always_comb begin
    nxt    = state;
    retire = 1'b0;
    to_err = 1'b0;
    case (state)
      S_IDLE: if (run) nxt = S_IF;
      S_IF:   nxt = S_ID;
      S_ID: begin
        case (cls_id)
          C_SYSTEM: nxt = S_HALT;
          C_NOP:    retire = 1'b1;
          default:  nxt = S_EXE;
        endcase
      end
      S_EXE: begin
        case (cls)
          C_LOAD, C_STORE: nxt = S_MEM;
          C_ALU:           nxt = S_WB;
          default:         retire = 1'b1;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (cls == C_LOAD) nxt = S_WB;
          else               retire = 1'b1;
        end else if (wait_cnt == WAIT_LAST) begin
          nxt    = S_HALT;
          to_err = 1'b1;
        end
      end
      S_WB:   retire = 1'b1;
      S_HALT: nxt = S_HALT;
      default: nxt = S_IDLE;
    endcase
    // retirement decides between fetching again and parking in IDLE
    if (retire) nxt = run ? S_IF : S_IDLE;
  end

  assign active = (state == S_IF) || (state == S_ID) ||
                  (state == S_EXE) || (state == S_MEM) ||
                  (state == S_WB);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cls         <= C_NOP;
      wait_cnt    <= '0;
      stateIF     <= 1'b0;
      stateID     <= 1'b0;
      stateEXE    <= 1'b0;
      stateMEM    <= 1'b0;
      stateWB     <= 1'b0;
      halted      <= 1'b0;
      mem_err     <= 1'b0;
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      state    <= nxt;
      stateIF  <= (nxt == S_IF);
      stateID  <= (nxt == S_ID);
      stateEXE <= (nxt == S_EXE);
      stateMEM <= (nxt == S_MEM);
      stateWB  <= (nxt == S_WB);
      halted   <= (nxt == S_HALT);
      if (to_err) mem_err <= 1'b1;
      if (state == S_ID) cls <= cls_id;
      if (state == S_MEM && !mem_ready)
        wait_cnt <= wait_cnt + WW'(1);
      else
        wait_cnt <= '0;
      if (active && cycle_count != CNT_MAX)
        cycle_count <= cycle_count + CNT_W'(1);
      if (retire && instr_count != CNT_MAX)
        instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule
